accel_cmd_regs: RTL and testbench
=================================

// Module: accel_cmd_regs
// PURPOSE
//  AXI4-Lite responder (slave) terminating the command-order bus driven by make_order on the accelerator side.
//  Decodes a small register map and holds task descriptors (feature/weight/output addresses, shape).
//  Issues a one-cycle task_start pulse to the compute datapath and tracks busy/done from task_finish.
//  Sits between the control-bus master and the accelerator core, on the core clock.
// PARAMETERS
//  ADDR_WIDTH  8             AXI-Lite byte address width; only addr[4:2] are decoded
//  DATA_WIDTH  32            AXI-Lite data width; fixed at 32, WSTRB = DATA_WIDTH/8
//  VERSION     32'h2024_0924 value returned by the read-only VERSION register
// PORTS
//  clk              in   1   core clock
//  rst              in   1   asynchronous reset, active-high
//  s00_axi_awaddr   in   8   write address
//  s00_axi_awprot   in   3   ignored
//  s00_axi_awvalid  in   1   / s00_axi_awready out 1   AW handshake
//  s00_axi_wdata    in   32  write data
//  s00_axi_wstrb    in   4   byte enables
//  s00_axi_wvalid   in   1   / s00_axi_wready out 1    W handshake
//  s00_axi_bresp    out  2   / s00_axi_bvalid out 1 / s00_axi_bready in 1
//  s00_axi_araddr   in   8   / s00_axi_arprot in 3 (ignored)
//  s00_axi_arvalid  in   1   / s00_axi_arready out 1
//  s00_axi_rdata    out  32  / s00_axi_rresp out 2 / s00_axi_rvalid out 1 / s00_axi_rready in 1
//  task_start       out  1   one-cycle start pulse to core
//  task_finish      in   1   one-cycle completion pulse from core
//  feat_addr, weight_addr, out_addr, task_shape  out 32 each  descriptor registers
// BEHAVIOUR
//  Reset: all readies 0 then high after reset; bvalid/rvalid/task_start/busy/done 0; all registers 0; resp 0.
//  Map: 0x00 CTRL (W: bit0=1 starts; reads 0) | 0x04 STATUS (R: bit0 busy, bit1 done; W: bit1=1 clears done)
//       0x08 FEAT_ADDR | 0x0C WEIGHT_ADDR | 0x10 OUT_ADDR | 0x14 SHAPE (RW, WSTRB per byte) | 0x18 VERSION (RO)
//  Unmapped/0x1C: write discarded, read data 0, resp SLVERR (2'b10); all else OKAY. Write to VERSION: OKAY, no effect.
//  Write channel: AW and W accepted independently, in any order or same cycle; awready drops once an address
//   is latched, wready once data is latched. When both held: commit registers next cycle, assert bvalid;
//   hold bvalid/bresp until bready; then reopen awready/wready. One outstanding write only.
//  Read channel: arready high in R_IDLE; on accept latch addr, go R_DATA, rvalid+rdata next cycle;
//   hold stable until rready; return to R_IDLE. Read and write channels run concurrently.
//  Start: CTRL bit0 commit with busy=0 -> task_start=1 exactly one cycle after commit cycle, busy=1 same cycle.
//   Start while busy: ignored, resp OKAY, no pulse.
//  task_finish with busy=1 -> busy=0, done=1 next cycle; task_finish with busy=0 ignored.
//  Same cycle done-clear write and task_finish: done=1 (set wins). Start commit same cycle as finish: finish
//   processed first, start accepted (busy stays 1, new pulse).
//  Reset mid-transaction: all handshakes abort, no response issued; master must reissue.
// CONFIGURATION
//  ACCEL_CMD_IRQ_EN defined: output irq (1 bit) = done & irq_enable; CTRL bit1 RW = irq_enable (reset 0);
//   level interrupt cleared by the STATUS done-clear write.
//  Not defined: no irq port; CTRL bit1 writes ignored, reads 0.
// STRUCTURE
//  Shared package accel_cmd_pkg: register offsets, OKAY/SLVERR codes, CTRL/STATUS bit indices, write/read
//   FSM state encodings. Single module; no sub-module required (write-capture logic kept inline).
// TESTING
//  Reset then read 0x18 -> rdata 32'h2024_0924, rresp 2'b00, rvalid held until rready.
//  W before AW (W at t0, AW at t0+3) to 0x08 data 32'hDEAD_BEEF strb 4'hF -> one bvalid OKAY; read 0x08 returns it.
//  Write 0x0C strb 4'b0101 data 32'h1122_3344 over 0 -> reads 32'h0022_0044.
//  Write 0x00 = 1 -> task_start one cycle, STATUS=1; second start while busy -> no pulse;
//   pulse task_finish -> STATUS=2; write 0x04 = 2 -> STATUS=0.
//  Write/read 0x1C -> bresp/rresp 2'b10, rdata 0, no register changed.
//  bready/rready held low 10 cycles -> bvalid/rvalid and data stable; ACCEL_CMD_IRQ_EN: irq rises with done.

Source files
------------

// File: rtl/accel_cmd_pkg.sv
// Shared definitions for the accelerator command register block: register map,
// AXI response codes, CTRL/STATUS bit positions and channel FSM encodings.
package accel_cmd_pkg;

  // Word index (addr[4:2]) of each register
  localparam logic [2:0] IdxCtrl     = 3'd0;
  localparam logic [2:0] IdxStatus   = 3'd1;
  localparam logic [2:0] IdxFeat     = 3'd2;
  localparam logic [2:0] IdxWeight   = 3'd3;
  localparam logic [2:0] IdxOut      = 3'd4;
  localparam logic [2:0] IdxShape    = 3'd5;
  localparam logic [2:0] IdxVersion  = 3'd6;
  localparam logic [2:0] IdxUnmapped = 3'd7;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlIrqEnBit  = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;

  typedef enum logic [1:0] {WrReset, WrCollect, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdReset, RdIdle, RdData} rd_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/accel_cmd_regs.sv
// AXI4-Lite command/descriptor register block for the accelerator core.
// Optional level interrupt enabled by defining ACCEL_CMD_IRQ_EN.
module accel_cmd_regs
  import accel_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] VERSION    = 32'h2024_0924
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]              s00_axi_awprot,
  input  logic                    s00_axi_awvalid,
  output logic                    s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                    s00_axi_wvalid,
  output logic                    s00_axi_wready,
  output logic [1:0]              s00_axi_bresp,
  output logic                    s00_axi_bvalid,
  input  logic                    s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]              s00_axi_arprot,
  input  logic                    s00_axi_arvalid,
  output logic                    s00_axi_arready,
  output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]              s00_axi_rresp,
  output logic                    s00_axi_rvalid,
  input  logic                    s00_axi_rready,
  output logic                    task_start,
  input  logic                    task_finish,
`ifdef ACCEL_CMD_IRQ_EN
  output logic                    irq,
`endif
  output logic [DATA_WIDTH-1:0]   feat_addr,
  output logic [DATA_WIDTH-1:0]   weight_addr,
  output logic [DATA_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   task_shape
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]              aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, rd_mux;
  logic [DATA_WIDTH-1:0]   feat_q, feat_d, weight_q, weight_d, out_q, out_d, shape_q, shape_d;
  logic                    busy_q, busy_d, done_q, done_d, start_q, start_d;
  logic                    irq_en_q, irq_en_d;
  logic                    wr_commit;
  logic                    unused_in;

  assign unused_in = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[ADDR_WIDTH-1:5],
                       s00_axi_awaddr[1:0], s00_axi_araddr[ADDR_WIDTH-1:5], s00_axi_araddr[1:0]};

  assign s00_axi_awready = (wr_state_q == WrCollect) && !aw_held_q;
  assign s00_axi_wready  = (wr_state_q == WrCollect) && !w_held_q;
  assign s00_axi_bvalid  = (wr_state_q == WrResp);
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = (rd_state_q == RdIdle);
  assign s00_axi_rvalid  = (rd_state_q == RdData);
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign wr_commit       = (wr_state_q == WrCollect) && aw_held_q && w_held_q;

  assign task_start  = start_q;
  assign feat_addr   = feat_q;
  assign weight_addr = weight_q;
  assign out_addr    = out_q;
  assign task_shape  = shape_q;
`ifdef ACCEL_CMD_IRQ_EN
  assign irq = done_q & irq_en_q;
`endif

  // Write channel: AW and W captured independently, committed once both are held
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WrReset: wr_state_d = WrCollect;
      WrCollect: begin
        if (s00_axi_awvalid && s00_axi_awready) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s00_axi_awaddr[4:2];
        end
        if (s00_axi_wvalid && s00_axi_wready) begin
          w_held_d = 1'b1;
          wdata_d  = s00_axi_wdata;
          wstrb_d  = s00_axi_wstrb;
        end
        if (wr_commit) begin
          wr_state_d = WrResp;
          bresp_d    = (aw_idx_q == IdxUnmapped) ? RespSlverr : RespOkay;
        end
      end
      WrResp: begin
        if (s00_axi_bready) begin
          wr_state_d = WrCollect;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WrReset;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[4:2])
      IdxCtrl: begin
`ifdef ACCEL_CMD_IRQ_EN
        rd_mux[CtrlIrqEnBit] = irq_en_q;
`endif
      end
      IdxStatus: begin
        rd_mux[StatusBusyBit] = busy_q;
        rd_mux[StatusDoneBit] = done_q;
      end
      IdxFeat:    rd_mux = feat_q;
      IdxWeight:  rd_mux = weight_q;
      IdxOut:     rd_mux = out_q;
      IdxShape:   rd_mux = shape_q;
      IdxVersion: rd_mux = VERSION;
      default:    rd_mux = '0;
    endcase
  end

  // Read data is captured at address accept so it stays stable while rvalid waits
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RdReset: rd_state_d = RdIdle;
      RdIdle: begin
        if (s00_axi_arvalid) begin
          rd_state_d = RdData;
          rdata_d    = rd_mux;
          rresp_d    = (s00_axi_araddr[4:2] == IdxUnmapped) ? RespSlverr : RespOkay;
        end
      end
      RdData:  if (s00_axi_rready) rd_state_d = RdIdle;
      default: rd_state_d = RdReset;
    endcase
  end

  // Ordering: done-clear, then finish (set wins), then start sees the post-finish busy
  always_comb begin
    feat_d   = feat_q;
    weight_d = weight_q;
    out_d    = out_q;
    shape_d  = shape_q;
    busy_d   = busy_q;
    done_d   = done_q;
    start_d  = 1'b0;
    irq_en_d = irq_en_q;
    if (wr_commit && aw_idx_q == IdxStatus && wstrb_q[0] && wdata_q[StatusDoneBit]) begin
      done_d = 1'b0;
    end
    if (task_finish && busy_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (wr_commit) begin
      case (aw_idx_q)
        IdxCtrl: begin
          if (wstrb_q[0] && wdata_q[CtrlStartBit] && !busy_d) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
`ifdef ACCEL_CMD_IRQ_EN
          if (wstrb_q[0]) irq_en_d = wdata_q[CtrlIrqEnBit];
`endif
        end
        IdxFeat:   feat_d   = apply_strb(feat_q, wdata_q, wstrb_q);
        IdxWeight: weight_d = apply_strb(weight_q, wdata_q, wstrb_q);
        IdxOut:    out_d    = apply_strb(out_q, wdata_q, wstrb_q);
        IdxShape:  shape_d  = apply_strb(shape_q, wdata_q, wstrb_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WrReset;
      rd_state_q <= RdReset;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RespOkay;
      rresp_q    <= RespOkay;
      rdata_q    <= '0;
      feat_q     <= '0;
      weight_q   <= '0;
      out_q      <= '0;
      shape_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      feat_q     <= feat_d;
      weight_q   <= weight_d;
      out_q      <= out_d;
      shape_q    <= shape_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      start_q    <= start_d;
      irq_en_q   <= irq_en_d;
    end
  end

endmodule

// File: tb/tb_accel_cmd_regs.sv
// Scoreboard bench for accel_cmd_regs: drivers queue expected B/R responses,
// a negedge monitor pops and compares on each handshake.
module tb_accel_cmd_regs;
  import accel_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        task_start, task_finish;
  logic [31:0] feat_addr, weight_addr, out_addr, task_shape;
`ifdef ACCEL_CMD_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [1:0]  bexp_q[$];
  logic [33:0] rexp_q[$];
  logic [1:0]  bexp;
  logic [33:0] rexp;

  accel_cmd_regs dut (
    .clk(clk), .rst(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .task_start(task_start), .task_finish(task_finish),
`ifdef ACCEL_CMD_IRQ_EN
    .irq(irq),
`endif
    .feat_addr(feat_addr), .weight_addr(weight_addr), .out_addr(out_addr),
    .task_shape(task_shape)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return awready;
      1: return wready;
      2: return arready;
      3: return bvalid;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sig(sel)) return;
    end
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=low required=high", name);
  endtask

  // Monitor: pulse bookkeeping and response scoreboard
  always @(negedge clk) begin
    if (task_start) begin
      start_cnt++;
      check("start_with_bvalid", {31'd0, bvalid}, 32'd1);
    end
    if (!rst && bvalid && bready) begin
      if (bexp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected actual=bvalid required=none");
      end else begin
        bexp = bexp_q.pop_front();
        check("bresp", {30'd0, bresp}, {30'd0, bexp});
      end
    end
    if (!rst && rvalid && rready) begin
      if (rexp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL r_unexpected actual=rvalid required=none");
      end else begin
        rexp = rexp_q.pop_front();
        check("rdata", rdata, rexp[33:2]);
        check("rresp", {30'd0, rresp}, {30'd0, rexp[1:0]});
      end
    end
  end

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_hold, input logic [1:0] exp);
    logic aw_done;
    logic [1:0] first;
    aw_done = 1'b0;
    bexp_q.push_back(exp);
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        #1 awaddr = addr; awvalid = 1'b1;
        wait_for("awready", 0);
        @(posedge clk); #1 awvalid = 1'b0; aw_done = 1'b1;
      end
      begin
        repeat (w_dly) @(posedge clk);
        #1 wdata = data; wstrb = strb; wvalid = 1'b1;
        wait_for("wready", 1);
        @(posedge clk); #1 wvalid = 1'b0;
        @(negedge clk);
        if (!aw_done) check("wready_drop", {31'd0, wready}, 32'd0);
      end
    join
    wait_for("bvalid", 3);
    first = bresp;
    repeat (b_hold) begin
      @(negedge clk);
      check("bvalid_held", {31'd0, bvalid}, 32'd1);
      check("bresp_stable", {30'd0, bresp}, {30'd0, first});
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input int r_hold,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] first;
    rexp_q.push_back({exp_data, exp_resp});
    @(posedge clk); #1 araddr = addr; arvalid = 1'b1;
    wait_for("arready", 2);
    @(posedge clk); #1 arvalid = 1'b0;
    wait_for("rvalid", 4);
    first = rdata;
    repeat (r_hold) begin
      @(negedge clk);
      check("rvalid_held", {31'd0, rvalid}, 32'd1);
      check("rdata_stable", rdata, first);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic pulse_finish();
    @(posedge clk); #1 task_finish = 1'b1;
    @(posedge clk); #1 task_finish = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    task_finish = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_task_start", {31'd0, task_start}, 32'd0);
    check("rst_feat", feat_addr, 32'd0);
    check("rst_weight", weight_addr, 32'd0);
    check("rst_out", out_addr, 32'd0);
    check("rst_shape", task_shape, 32'd0);
    check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);

    // VERSION read with rready held off
    axi_read(8'h18, 10, 32'h2024_0924, RespOkay);

    // W three cycles ahead of AW
    axi_write(8'h08, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, RespOkay);
    check("feat_out", feat_addr, 32'hDEAD_BEEF);
    axi_read(8'h08, 0, 32'hDEAD_BEEF, RespOkay);

    // Partial strobe; AW ahead of W, bready held off
    axi_write(8'h0C, 32'h1122_3344, 4'b0101, 0, 2, 10, RespOkay);
    check("weight_out", weight_addr, 32'h0022_0044);
    axi_read(8'h0C, 0, 32'h0022_0044, RespOkay);
    axi_write(8'h10, 32'hCAFE_0000, 4'hF, 0, 0, 0, RespOkay);
    axi_write(8'h14, 32'hFFFF_1234, 4'b0011, 1, 1, 0, RespOkay);
    axi_read(8'h14, 0, 32'h0000_1234, RespOkay);

    // Start / busy / done sequence
    start_cnt = 0;
    axi_write(8'h00, 32'h1, 4'hF, 0, 0, 0, RespOkay);
    repeat (2) @(negedge clk);
    check("start_pulses", start_cnt, 32'd1);
    axi_read(8'h04, 0, 32'h1, RespOkay);
    axi_write(8'h00, 32'h1, 4'hF, 0, 0, 0, RespOkay);
    repeat (2) @(negedge clk);
    check("start_while_busy", start_cnt, 32'd1);
    axi_read(8'h00, 0, 32'h0, RespOkay);
    pulse_finish();
    axi_read(8'h04, 0, 32'h2, RespOkay);
    axi_write(8'h04, 32'h2, 4'hF, 0, 0, 0, RespOkay);
    axi_read(8'h04, 0, 32'h0, RespOkay);
    pulse_finish();
    axi_read(8'h04, 0, 32'h0, RespOkay);

    // Unmapped and read-only targets
    axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, RespSlverr);
    axi_read(8'h1C, 0, 32'h0, RespSlverr);
    axi_write(8'h18, 32'h1234_5678, 4'hF, 0, 0, 0, RespOkay);
    axi_read(8'h18, 0, 32'h2024_0924, RespOkay);
    check("feat_kept", feat_addr, 32'hDEAD_BEEF);
    check("weight_kept", weight_addr, 32'h0022_0044);
    check("out_kept", out_addr, 32'hCAFE_0000);
    check("shape_kept", task_shape, 32'h0000_1234);

`ifdef ACCEL_CMD_IRQ_EN
    axi_write(8'h00, 32'h2, 4'hF, 0, 0, 0, RespOkay);
    axi_read(8'h00, 0, 32'h2, RespOkay);
    axi_write(8'h00, 32'h3, 4'hF, 0, 0, 0, RespOkay);
    @(negedge clk);
    check("irq_busy", {31'd0, irq}, 32'd0);
    pulse_finish();
    @(negedge clk);
    check("irq_done", {31'd0, irq}, 32'd1);
    axi_write(8'h04, 32'h2, 4'hF, 0, 0, 0, RespOkay);
    @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
`else
    start_cnt = 0;
    axi_write(8'h00, 32'h2, 4'hF, 0, 0, 0, RespOkay);
    axi_read(8'h00, 0, 32'h0, RespOkay);
    repeat (2) @(negedge clk);
    check("ctrl_bit1_no_start", start_cnt, 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("b_queue_drained", bexp_q.size(), 32'd0);
    check("r_queue_drained", rexp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
